// File: rtl/proc_result_serializer.sv
// Result serializer: buffers ALU results in a small FIFO and sends each one
// as a start/data(LSB first)/stop frame on a single registered tx pin.
module proc_result_serializer #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  state_t            state_r, state_s;
  logic [TICK_W-1:0] tick_r, tick_s;
  logic [BIT_W-1:0]  bit_r, bit_s;
  logic [DATA_W-1:0] shreg_r, shreg_s;
  logic              tx_r, tx_s;
  logic              busy_r;
  logic              push_s, pop_s, not_empty_s, tick_last_s;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign res_ready   = (count_r != FULL_CNT);
  assign push_s      = res_valid && res_ready;
  assign not_empty_s = (count_r != {CNT_W{1'b0}});
  assign tick_last_s = (tick_r == TICK_LAST);

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

  // FIFO storage write port (no reset needed; validity tracked by count).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= res_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (res_valid && !res_ready) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Frame FSM next-state; tx is derived from the next state so the pin is registered.
  always_comb begin
    state_s = state_r;
    tick_s  = tick_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (not_empty_s) begin
          pop_s   = 1'b1;
          shreg_s = mem_r[rd_ptr_r];
          state_s = START;
          tick_s  = {TICK_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_last_s) begin
          state_s = DATA;
          tick_s  = {TICK_W{1'b0}};
          bit_s   = {BIT_W{1'b0}};
        end else begin
          tick_s = tick_r + TICK_W'(1);
        end
      end
      DATA: begin
        if (tick_last_s) begin
          tick_s  = {TICK_W{1'b0}};
          shreg_s = shreg_r >> 1;
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + BIT_W'(1);
          end
        end else begin
          tick_s = tick_r + TICK_W'(1);
        end
      end
      STOP: begin
        if (tick_last_s) begin
          tick_s = {TICK_W{1'b0}};
          if (not_empty_s) begin
            // Back-to-back frames: reload straight into START, no idle gap.
            pop_s   = 1'b1;
            shreg_s = mem_r[rd_ptr_r];
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          tick_s = tick_r + TICK_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shreg_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // Frame FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      tick_r  <= {TICK_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      shreg_r <= {DATA_W{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tick_r  <= tick_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_proc_result_serializer.sv
// Bench for proc_result_serializer: directed scenarios plus random traffic,
// every cycle compared against a queue-based frame-timeline model.
module tb_proc_result_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic          res_valid = 1'b0;
  logic          res_ready, tx, busy, overflow;
  logic [2:0]    fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: buffered words, remaining cycles of the current frame.
  int       q[$];
  int       frame_rem = 0;
  logic [7:0] cur_byte = 8'h00;
  logic     ovf_m = 1'b0;
  int       busy_seen = 0;
  int       peak_cnt = 0;

  proc_result_serializer #(.DATA_W(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    int p, b;
    if (frame_rem == 0) return 1'b1;
    p = FRAME - frame_rem;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return cur_byte[b-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d);
    logic acc;
    acc = (q.size() < DEPTH);
    if (frame_rem <= 1 && q.size() > 0) begin
      cur_byte  = 8'(q.pop_front());
      frame_rem = FRAME;
    end else if (frame_rem > 0) begin
      frame_rem--;
    end
    if (v) begin
      if (acc) q.push_back(int'(d));
      else     ovf_m = 1'b1;
    end
  endtask

  task automatic check_all();
    check("tx",         32'(tx),         32'(model_tx()));
    check("busy",       32'(busy),       32'(frame_rem > 0));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("res_ready",  32'(res_ready),  32'(q.size() < DEPTH));
    check("overflow",   32'(overflow),   32'(ovf_m));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    res_valid = v;
    res_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    check_all();
    if (busy) busy_seen++;
    if (int'(fifo_count) > peak_cnt) peak_cnt = int'(fifo_count);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (frame_rem > 0 || q.size() > 0); i++) cyc(1'b0, 8'h00);
    res_valid = 1'b0;
  endtask

  // Reset with garbage pushes applied; everything must stay at reset values.
  task automatic do_reset();
    rst_n     = 1'b0;
    res_valid = 1'b1;
    res_data  = 8'hFF;
    q.delete();
    frame_rem = 0;
    ovf_m     = 1'b0;
    #1;
    check("rst_tx_now",    32'(tx),         32'd1);
    check("rst_busy_now",  32'(busy),       32'd0);
    check("rst_count_now", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_tx",       32'(tx),         32'd1);
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_count",    32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
      check("rst_ready",    32'(res_ready),  32'd1);
    end
    res_valid = 1'b0;
    rst_n     = 1'b1;
    busy_seen = 0;
    peak_cnt  = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single frame of A5: 40 busy cycles.
    cyc(1'b1, 8'hA5);
    drain();
    check("single_busy_len", 32'(busy_seen), 32'd40);

    // Back-to-back frames.
    busy_seen = 0; peak_cnt = 0;
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    cyc(1'b1, 8'h03);
    drain();
    check("b2b_busy_len", 32'(busy_seen), 32'd120);
    check("b2b_peak",     32'(peak_cnt),  32'd2);

    // Full / overflow: six pushes, the sixth dropped.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h10 + i));
    check("ovf_set",   32'(overflow),   32'd1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    drain();
    check("ovf_busy_len", 32'(busy_seen), 32'd200);
    check("ovf_sticky",   32'(overflow),  32'd1);

    // Push while full on the STOP-end pop edge is rejected.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 200 && frame_rem != 1; i++) cyc(1'b0, 8'h00);
    check("pf_frame_rem", 32'(frame_rem),  32'd1);
    check("pf_ready",     32'(res_ready),  32'd0);
    check("pf_count_pre", 32'(fifo_count), 32'd4);
    check("pf_ovf_pre",   32'(overflow),   32'd0);
    cyc(1'b1, 8'h99);
    check("pf_count_post", 32'(fifo_count), 32'd3);
    check("pf_ovf_post",   32'(overflow),   32'd1);
    drain();

    // Mid-frame reset during data bit 3, then a clean frame.
    do_reset();
    cyc(1'b1, 8'h3C);
    for (int i = 0; i < 200 && (FRAME - frame_rem) != 4 * CPB + 1; i++) cyc(1'b0, 8'h00);
    check("mf_tx_bit3", 32'(tx), 32'(1'b1));
    do_reset();
    busy_seen = 0;
    cyc(1'b1, 8'h81);
    drain();
    check("mf_busy_len", 32'(busy_seen), 32'd40);

    // Random traffic with varying push density.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int pct;
      pct = (blk % 4 == 0) ? 90 : (blk % 4 == 1) ? 3 : (blk % 4 == 2) ? 25 : 50;
      for (int i = 0; i < 400; i++)
        cyc($urandom_range(0, 99) < pct, 8'($urandom));
      if (blk == 3) do_reset();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
